// File: rtl/flex_pkg.sv
// Shared constants and helpers for the glove flex-sensor input conditioner.
// Status word bit positions are fixed by the processor's MMIO register map.
package flex_pkg;

  localparam int unsigned STATUS_W = 32;
  localparam int unsigned HOLD_W   = 12;
  localparam int unsigned HOLD_MAX = 4095;

  localparam int unsigned ST_LVL_R      = 0;
  localparam int unsigned ST_LVL_L      = 1;
  localparam int unsigned ST_PRESS_R    = 2;
  localparam int unsigned ST_PRESS_L    = 3;
  localparam int unsigned ST_REL_R      = 4;
  localparam int unsigned ST_REL_L      = 5;
  localparam int unsigned ST_HOLD_R_LSB = 8;
  localparam int unsigned ST_HOLD_L_LSB = 20;

  // Saturating hold increment: a long press pins at HOLD_MAX instead of wrapping.
  function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] h);
    return (h == HOLD_W'(HOLD_MAX)) ? h : h + HOLD_W'(1);
  endfunction

endpackage

// File: rtl/flex_channel.sv
// One glove channel: pin synchronizer, polarity fix, debounce, edge pulses
// and a prescaled, saturating hold-duration counter.
module flex_channel
  import flex_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_TICK       = 50000,
  parameter bit          ACTIVE_HIGH     = 1'b1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              pin,
  output logic              stable,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic [HOLD_W-1:0] hold
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PS_W = (HOLD_TICK > 1) ? $clog2(HOLD_TICK) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(HOLD_TICK - 1);

  logic            sync_q1;
  logic            sync_q2;
  logic [DB_W-1:0] db_q;
  logic [PS_W-1:0] presc_q;
  logic            s_c;
  logic            flip_c;

  assign s_c    = ACTIVE_HIGH ? sync_q2 : ~sync_q2;
  // Level change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
  assign flip_c = (s_c != stable) && (db_q == DB_LAST);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1       <= 1'b0;
      sync_q2       <= 1'b0;
      db_q          <= '0;
      stable        <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      presc_q       <= '0;
      hold          <= '0;
    end else begin
      sync_q1       <= pin;
      sync_q2       <= sync_q1;
      press_pulse   <= flip_c & ~stable;
      release_pulse <= flip_c & stable;

      if (s_c == stable) begin
        db_q <= '0;
      end else if (flip_c) begin
        db_q   <= '0;
        stable <= ~stable;
      end else begin
        db_q <= db_q + DB_W'(1);
      end

      // Hold restarts on press, counts ticks while pressed, freezes while released.
      if (flip_c && !stable) begin
        presc_q <= '0;
        hold    <= '0;
      end else if (stable) begin
        if (presc_q == PS_LAST) begin
          presc_q <= '0;
          hold    <= hold_inc(hold);
        end else begin
          presc_q <= presc_q + PS_W'(1);
        end
      end else begin
        presc_q <= '0;
      end
    end
  end

endmodule

// File: rtl/flex_input_conditioner.sv
// Two-channel glove flex-sensor conditioner: per-channel debounce/hold plus
// read-clear event latches and a registered 32-bit status word for polling.
module flex_input_conditioner
  import flex_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_TICK       = 50000,
  parameter bit          ACTIVE_HIGH     = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flex_right,
  input  logic                flex_left,
  input  logic                status_rd,
  output logic [STATUS_W-1:0] status_word,
  output logic                press_irq
);

  logic [1:0]          rst_sync_q;
  logic                rst_n;
  logic                stable_r, stable_l;
  logic                press_r, press_l;
  logic                rel_r, rel_l;
  logic [HOLD_W-1:0]   hold_r, hold_l;
  logic [1:0]          press_evt_q, rel_evt_q;
  logic [1:0]          press_evt_d, rel_evt_d;
  logic [STATUS_W-1:0] status_d;

  // Async assert, synchronous release of the internal reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  flex_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_TICK      (HOLD_TICK),
    .ACTIVE_HIGH    (ACTIVE_HIGH)
  ) u_right (
    .clock        (clock),
    .rst_n        (rst_n),
    .pin          (flex_right),
    .stable       (stable_r),
    .press_pulse  (press_r),
    .release_pulse(rel_r),
    .hold         (hold_r)
  );

  flex_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_TICK      (HOLD_TICK),
    .ACTIVE_HIGH    (ACTIVE_HIGH)
  ) u_left (
    .clock        (clock),
    .rst_n        (rst_n),
    .pin          (flex_left),
    .stable       (stable_l),
    .press_pulse  (press_l),
    .release_pulse(rel_l),
    .hold         (hold_l)
  );

  // A new event in the read cycle wins over the read-clear.
  always_comb begin
    press_evt_d = {press_l, press_r} | (press_evt_q & ~{2{status_rd}});
    rel_evt_d   = {rel_l, rel_r}     | (rel_evt_q   & ~{2{status_rd}});

    status_d                                = '0;
    status_d[ST_LVL_R]                      = stable_r;
    status_d[ST_LVL_L]                      = stable_l;
    status_d[ST_PRESS_R]                    = press_evt_d[0];
    status_d[ST_PRESS_L]                    = press_evt_d[1];
    status_d[ST_REL_R]                      = rel_evt_d[0];
    status_d[ST_REL_L]                      = rel_evt_d[1];
    status_d[ST_HOLD_R_LSB +: HOLD_W]       = hold_r;
    status_d[ST_HOLD_L_LSB +: HOLD_W]       = hold_l;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      press_evt_q <= 2'b00;
      rel_evt_q   <= 2'b00;
      status_word <= '0;
      press_irq   <= 1'b0;
    end else begin
      press_evt_q <= press_evt_d;
      rel_evt_q   <= rel_evt_d;
      status_word <= status_d;
      press_irq   <= |press_evt_d;
    end
  end

endmodule

// File: tb/tb_flex_input_conditioner.sv
// Bench for flex_input_conditioner: two instances (active-high / active-low)
// checked every cycle against a sample-history reference model.
module tb_flex_input_conditioner;

  localparam int unsigned DB       = 4;
  localparam int unsigned HT_A     = 3;
  localparam int unsigned HT_B     = 1;
  localparam int unsigned HOLD_CAP = 4095;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  pins;
  logic [1:0]  rd;
  logic [31:0] st_a, st_b;
  logic        irq_a, irq_b;

  always #5 clock = ~clock;

  flex_input_conditioner #(.DEBOUNCE_CYCLES(DB), .HOLD_TICK(HT_A), .ACTIVE_HIGH(1'b1)) dut_a (
    .clock(clock), .reset(reset), .flex_right(pins[0]), .flex_left(pins[1]),
    .status_rd(rd[0]), .status_word(st_a), .press_irq(irq_a)
  );

  flex_input_conditioner #(.DEBOUNCE_CYCLES(DB), .HOLD_TICK(HT_B), .ACTIVE_HIGH(1'b0)) dut_b (
    .clock(clock), .reset(reset), .flex_right(pins[2]), .flex_left(pins[3]),
    .status_rd(rd[1]), .status_word(st_b), .press_irq(irq_b)
  );

  // Reference model: channel c = {A right, A left, B right, B left}.
  bit          stable_m[4], rose_m[4], fell_m[4], pevt_m[4], revt_m[4];
  bit          seen0[4], seen1[4];
  int unsigned run_m[4], since_m[4], hold_m[4];
  int unsigned rel_cnt;
  logic [31:0] exp_st[2];
  bit          exp_irq[2];
  int          tests = 0;
  int          fails = 0;

  task automatic model_edge();
    if (!reset) begin
      for (int c = 0; c < 4; c++) begin
        stable_m[c] = 0; rose_m[c] = 0; fell_m[c] = 0; pevt_m[c] = 0; revt_m[c] = 0;
        seen0[c] = 0; seen1[c] = 0; run_m[c] = 0; since_m[c] = 0; hold_m[c] = 0;
      end
      rel_cnt = 0;
      exp_st[0] = '0; exp_st[1] = '0; exp_irq[0] = 0; exp_irq[1] = 0;
    end else if (rel_cnt < 2) begin
      rel_cnt++;
    end else begin
      for (int c = 0; c < 4; c++) begin
        pevt_m[c] = rose_m[c] | (pevt_m[c] & !rd[c/2]);
        revt_m[c] = fell_m[c] | (revt_m[c] & !rd[c/2]);
      end
      for (int d = 0; d < 2; d++) begin
        logic [31:0] w;
        w = '0;
        w[0] = stable_m[2*d];  w[1] = stable_m[2*d+1];
        w[2] = pevt_m[2*d];    w[3] = pevt_m[2*d+1];
        w[4] = revt_m[2*d];    w[5] = revt_m[2*d+1];
        w[19:8]  = 12'(hold_m[2*d]);
        w[31:20] = 12'(hold_m[2*d+1]);
        exp_st[d]  = w;
        exp_irq[d] = pevt_m[2*d] | pevt_m[2*d+1];
      end
      for (int c = 0; c < 4; c++) begin
        bit          s;
        int unsigned ht;
        ht = (c < 2) ? HT_A : HT_B;
        s  = (c < 2) ? seen1[c] : !seen1[c];
        rose_m[c] = 0;
        fell_m[c] = 0;
        if (stable_m[c]) begin
          since_m[c]++;
          hold_m[c] = (since_m[c] / ht > HOLD_CAP) ? HOLD_CAP : since_m[c] / ht;
        end
        if (s != stable_m[c]) begin
          run_m[c]++;
          if (run_m[c] == DB) begin
            stable_m[c] = !stable_m[c];
            run_m[c] = 0;
            if (stable_m[c]) begin
              rose_m[c] = 1; since_m[c] = 0; hold_m[c] = 0;
            end else begin
              fell_m[c] = 1;
            end
          end
        end else begin
          run_m[c] = 0;
        end
        seen1[c] = seen0[c];
        seen0[c] = pins[c];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    chk("status_a", st_a, exp_st[0]);
    chk("irq_a", {31'b0, irq_a}, {31'b0, exp_irq[0]});
    chk("status_b", st_b, exp_st[1]);
    chk("irq_b", {31'b0, irq_b}, {31'b0, exp_irq[1]});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_bit(input string tag, input int d, input int bitn, input logic val);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if ((d == 0 ? st_a[bitn] : st_b[bitn]) === val) begin
        ok = 1;
        break;
      end
      tick();
    end
    tests++;
    assert (ok) else begin
      fails++;
      $error("FAIL %s: bit %0d never reached %b within 40 cycles", tag, bitn, val);
    end
  endtask

  task automatic read_once(input int d);
    rd[d] = 1'b1;
    tick();
    rd[d] = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    pins  = 4'b1111;
    rd    = 2'b00;

    // Reset held with both A pins high: everything stays zero.
    ticks(6);
    chk("reset_status", st_a, 32'h0);
    chk("reset_irq", {31'b0, irq_a}, 32'h0);
    reset = 1'b1;
    wait_bit("rst_press", 0, 0, 1'b1);
    chk("rst_press_word", st_a, 32'h0000_000F);
    read_once(0);
    pins[1:0] = 2'b00;
    ticks(12);
    read_once(0);

    // Glitch rejection, then a long pulse.
    pins[0] = 1'b1;
    ticks($urandom_range(1, 3));
    pins[0] = 1'b0;
    ticks(10);
    chk("glitch_lvl", {31'b0, st_a[0]}, 32'h0);
    pins[0] = 1'b1;
    ticks($urandom_range(8, 12));
    pins[0] = 1'b0;
    wait_bit("long_rel", 0, 4, 1'b1);
    read_once(0);

    // Hold count on the left channel.
    pins[1] = 1'b1;
    wait_bit("hold_press", 0, 1, 1'b1);
    ticks(39);
    chk("hold_13", {20'b0, st_a[31:20]}, 32'd13);
    pins[1] = 1'b0;
    wait_bit("hold_rel", 0, 1, 1'b0);
    ticks(5);
    pins[1] = 1'b1;
    wait_bit("hold_repress", 0, 1, 1'b1);
    chk("hold_cleared", {20'b0, st_a[31:20]}, 32'd0);
    pins[1] = 1'b0;
    wait_bit("hold_rel2", 0, 1, 1'b0);
    read_once(0);
    ticks(3);

    // Read-clear of a right press.
    pins[0] = 1'b1;
    wait_bit("rc_press", 0, 2, 1'b1);
    chk("rc_read_cycle", {31'b0, st_a[2]}, 32'h1);
    read_once(0);
    chk("rc_cleared", {31'b0, st_a[2]}, 32'h0);
    chk("rc_irq", {31'b0, irq_a}, 32'h0);
    chk("rc_level", {31'b0, st_a[0]}, 32'h1);

    // Set wins: read strobe held across the left acceptance.
    rd[0]   = 1'b1;
    pins[1] = 1'b1;
    wait_bit("sw_press", 0, 1, 1'b1);
    chk("sw_evt", {31'b0, st_a[3]}, 32'h1);
    chk("sw_irq", {31'b0, irq_a}, 32'h1);
    tick();
    rd[0] = 1'b0;
    ticks(2);

    // Reset mid-press: async clear, then a fresh simultaneous press.
    reset = 1'b0;
    #1;
    chk("midrst_status", st_a, 32'h0);
    chk("midrst_irq", {31'b0, irq_a}, 32'h0);
    ticks(3);
    reset = 1'b1;
    wait_bit("midrst_press", 0, 0, 1'b1);
    chk("midrst_both", {28'b0, st_a[3:0]}, 32'hF);
    pins[1:0] = 2'b00;
    ticks(12);
    read_once(0);

    // Active-low instance: low pin is pressed; hold saturates.
    pins[2] = 1'b0;
    wait_bit("pol_press", 1, 0, 1'b1);
    ticks(5000);
    chk("sat_hold", {20'b0, st_b[19:8]}, 32'd4095);
    pins[2] = 1'b1;
    ticks(10);
    chk("sat_kept", {20'b0, st_b[19:8]}, 32'd4095);

    // Random pin activity and read strobes on both instances.
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 7) == 0) pins[p] = ~pins[p];
      end
      rd[0] = ($urandom_range(0, 4) == 0);
      rd[1] = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
